mux_skid_stage: RTL and testbench

Parametrised N-way operand select mux feeding a registered pipeline stage. It has a valid/ready handshake and a two-entry skid buffer, so a single stage can select among forwarding sources, hold through downstream stalls without combinational ready paths, and be flushed on a branch redirect. It sits between the hazard/forwarding logic and the EX-stage operand registers, and replaces the fixed 32-bit two-input select.

---
 rtl/mux_skid_pkg.sv | 16 +
 rtl/mux_skid_stage_mux_n.sv | 27 ++
 rtl/mux_skid_stage.sv | 130 +++++++++++++
 tb/tb_mux_skid_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_skid_pkg.sv
// Shared types and helpers for the operand-select skid stage.
// Holds the occupancy state encoding and the select-width calculation.
package mux_skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // A single select bit is the minimum even for degenerate input counts.
    function automatic int calc_sel_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_skid_stage_mux_n.sv
// Combinational N-way select over a packed input bus.
// Selects beyond N_IN yield zero and raise out_of_range.
module mux_n
    import mux_skid_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N_IN  = 4,
    localparam int SEL_W = calc_sel_w(N_IN)
) (
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      data,
    output logic                  out_of_range
);

    always_comb begin
        data         = '0;
        out_of_range = 1'b1;
        for (int k = 0; k < N_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                data         = in_data[k*WIDTH +: WIDTH];
                out_of_range = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_skid_stage.sv
// Operand-select pipeline stage with a two-entry skid buffer and flush.
// in_ready is registered so out_ready never reaches it combinationally.
module mux_skid_stage
    import mux_skid_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N_IN  = 4,
    localparam int SEL_W = calc_sel_w(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err
);

    state_t             r_state;
    logic               r_in_ready;
    logic [WIDTH-1:0]   r_main_data;
    logic [SEL_W-1:0]   r_main_sel;
    logic [WIDTH-1:0]   r_skid_data;
    logic [SEL_W-1:0]   r_skid_sel;
    logic               r_sel_err;

    state_t             w_next_state;
    logic               w_next_ready;
    logic               w_load_main_mux;
    logic               w_load_main_skid;
    logic               w_load_skid;
    logic               w_accept;
    logic               w_pop;
    logic [WIDTH-1:0]   w_mux_data;
    logic               w_mux_oor;

    mux_n #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN)
    ) u_mux (
        .in_data      (in_data),
        .sel          (in_sel),
        .data         (w_mux_data),
        .out_of_range (w_mux_oor)
    );

    assign w_accept  = in_valid & r_in_ready;
    assign w_pop     = out_valid & out_ready;
    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_main_data;
    assign out_sel   = r_main_sel;
    assign sel_err   = r_sel_err;

    // Flush overrides every transition and suppresses all register loads.
    always_comb begin
        w_next_state     = r_state;
        w_load_main_mux  = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_next_state    = ONE;
                    w_load_main_mux = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && !w_pop) begin
                    w_next_state = FULL;
                    w_load_skid  = 1'b1;
                end else if (w_pop && !w_accept) begin
                    w_next_state = EMPTY;
                end else if (w_accept && w_pop) begin
                    w_load_main_mux = 1'b1;
                end
            end
            FULL: begin
                if (w_pop) begin
                    w_next_state     = ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_next_state = EMPTY;
            end
        endcase
        if (flush) begin
            w_next_state     = EMPTY;
            w_load_main_mux  = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
        w_next_ready = (w_next_state != FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_sel_err   <= 1'b0;
            r_main_data <= '0;
            r_main_sel  <= '0;
            r_skid_data <= '0;
            r_skid_sel  <= '0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= w_next_ready;
            // An out-of-range accept is reported even when the beat is flushed.
            r_sel_err  <= w_accept & w_mux_oor;
            if (w_load_main_mux) begin
                r_main_data <= w_mux_data;
                r_main_sel  <= in_sel;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_sel  <= r_skid_sel;
            end
            if (w_load_skid) begin
                r_skid_data <= w_mux_data;
                r_skid_sel  <= in_sel;
            end
        end
    end

endmodule

// File: tb/tb_mux_skid_stage.sv
// Directed bench for mux_skid_stage: a cycle table for the 4-input stage,
// random streaming, a 3-input instance for select errors, and async reset.
module tb_mux_skid_stage;

    typedef struct {
        logic         inValid;
        logic [1:0]   inSel;
        logic [127:0] inData;
        logic         outReady;
        logic         flush;
        logic         expValid;
        logic         expReady;
        logic         chkData;
        logic [31:0]  expData;
        logic [1:0]   expSel;
    } vec_t;

    localparam logic [127:0] P1 = 128'h00000044_00000033_00000022_00000011;
    localparam logic [127:0] P2 = 128'h000000D4_000000C3_000000B2_000000A1;

    logic         clk;
    logic         rst_n;

    logic [127:0] inData;
    logic [1:0]   inSel;
    logic         inValid;
    logic         inReady;
    logic         flush;
    logic [31:0]  outData;
    logic [1:0]   outSel;
    logic         outValid;
    logic         outReady;
    logic         selErr;

    logic [95:0]  d3InData;
    logic [1:0]   d3InSel;
    logic         d3InValid;
    logic         d3InReady;
    logic         d3Flush;
    logic [31:0]  d3OutData;
    logic [1:0]   d3OutSel;
    logic         d3OutValid;
    logic         d3OutReady;
    logic         d3SelErr;

    int nChecks = 0;
    int nPass   = 0;
    vec_t vecs[17];

    mux_skid_stage #(.WIDTH(32), .N_IN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (inData),
        .in_sel    (inSel),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .flush     (flush),
        .out_data  (outData),
        .out_sel   (outSel),
        .out_valid (outValid),
        .out_ready (outReady),
        .sel_err   (selErr)
    );

    mux_skid_stage #(.WIDTH(32), .N_IN(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (d3InData),
        .in_sel    (d3InSel),
        .in_valid  (d3InValid),
        .in_ready  (d3InReady),
        .flush     (d3Flush),
        .out_data  (d3OutData),
        .out_sel   (d3OutSel),
        .out_valid (d3OutValid),
        .out_ready (d3OutReady),
        .sel_err   (d3SelErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp)
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        else
            nPass++;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [127:0] d,
                                 input logic ordy, input logic fl);
        inValid  = v;
        inSel    = s;
        inData   = d;
        outReady = ordy;
        flush    = fl;
    endtask

    task automatic apply3(input logic v, input logic [1:0] s, input logic ordy, input logic fl);
        d3InValid  = v;
        d3InSel    = s;
        d3OutReady = ordy;
        d3Flush    = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [31:0] words[4];
        logic [1:0]  s;

        vecs[0]  = '{1'b1, 2'd2, P1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h33, 2'd2};
        vecs[1]  = '{1'b0, 2'd0, P1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0};
        vecs[2]  = '{1'b1, 2'd0, P1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 2'd0};
        vecs[3]  = '{1'b1, 2'd1, P2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h11, 2'd0};
        vecs[4]  = '{1'b1, 2'd3, P1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h11, 2'd0};
        vecs[5]  = '{1'b0, 2'd0, P1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hB2, 2'd1};
        vecs[6]  = '{1'b0, 2'd0, P1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0};
        vecs[7]  = '{1'b1, 2'd3, P1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44, 2'd3};
        vecs[8]  = '{1'b1, 2'd0, P2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h44, 2'd3};
        vecs[9]  = '{1'b1, 2'd2, P1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0};
        vecs[10] = '{1'b0, 2'd0, P1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0};
        vecs[11] = '{1'b1, 2'd1, P1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h22, 2'd1};
        vecs[12] = '{1'b1, 2'd2, P1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0};
        vecs[13] = '{1'b1, 2'd0, P2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA1, 2'd0};
        vecs[14] = '{1'b0, 2'd0, P2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA1, 2'd0};
        vecs[15] = '{1'b1, 2'd3, P2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hD4, 2'd3};
        vecs[16] = '{1'b0, 2'd0, P2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0};

        rst_n = 1'b0;
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 1'b0);
        d3InData = {32'h00000C03, 32'h00000B02, 32'h00000A01};
        apply3(1'b0, 2'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", inReady, 1);
        checkOutput("reset_out_valid", outValid, 0);
        checkOutput("reset_out_data", outData, 0);
        checkOutput("reset_out_sel", outSel, 0);
        checkOutput("reset_sel_err", selErr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cycle table: each row is driven before an edge and checked after it.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].inValid, vecs[i].inSel, vecs[i].inData,
                          vecs[i].outReady, vecs[i].flush);
            tick();
            checkOutput($sformatf("vec%0d_out_valid", i), outValid, vecs[i].expValid);
            checkOutput($sformatf("vec%0d_in_ready", i), inReady, vecs[i].expReady);
            checkOutput($sformatf("vec%0d_sel_err", i), selErr, 0);
            if (vecs[i].chkData) begin
                checkOutput($sformatf("vec%0d_out_data", i), outData, vecs[i].expData);
                checkOutput($sformatf("vec%0d_out_sel", i), outSel, vecs[i].expSel);
            end
        end

        // Back-to-back random beats with the sink always ready.
        for (int b = 0; b < 100; b++) begin
            for (int k = 0; k < 4; k++) words[k] = $urandom;
            s = 2'($urandom_range(0, 3));
            applyStimulus(1'b1, s, {words[3], words[2], words[1], words[0]}, 1'b1, 1'b0);
            tick();
            checkOutput($sformatf("stream%0d", b), {outValid, inReady, outSel, outData},
                        {1'b1, 1'b1, s, words[s]});
        end
        applyStimulus(1'b0, 2'd0, P1, 1'b1, 1'b0);
        tick();
        checkOutput("stream_drain_valid", outValid, 0);

        // Three-input instance: select 3 is out of range.
        apply3(1'b1, 2'd1, 1'b1, 1'b0);
        tick();
        checkOutput("oor_pre_data", d3OutData, 32'hB02);
        checkOutput("oor_pre_err", d3SelErr, 0);
        apply3(1'b1, 2'd3, 1'b1, 1'b0);
        tick();
        checkOutput("oor_data", d3OutData, 0);
        checkOutput("oor_sel", d3OutSel, 3);
        checkOutput("oor_valid", d3OutValid, 1);
        checkOutput("oor_err", d3SelErr, 1);
        apply3(1'b0, 2'd0, 1'b1, 1'b0);
        tick();
        checkOutput("oor_err_one_cycle", d3SelErr, 0);
        checkOutput("oor_drained", d3OutValid, 0);
        apply3(1'b1, 2'd3, 1'b1, 1'b1);
        tick();
        checkOutput("oor_flush_err", d3SelErr, 1);
        checkOutput("oor_flush_valid", d3OutValid, 0);
        apply3(1'b0, 2'd0, 1'b1, 1'b0);
        tick();
        checkOutput("oor_flush_err_clear", d3SelErr, 0);

        // Fill to FULL, then pull reset between edges.
        applyStimulus(1'b1, 2'd0, P1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 2'd1, P1, 1'b0, 1'b0);
        tick();
        checkOutput("arst_full_in_ready", inReady, 0);
        applyStimulus(1'b0, 2'd0, P1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", outValid, 0);
        checkOutput("arst_in_ready", inReady, 1);
        checkOutput("arst_out_data", outData, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 2'd2, P1, 1'b1, 1'b0);
        tick();
        checkOutput("arst_after_data", outData, 32'h33);
        checkOutput("arst_after_valid", outValid, 1);
        applyStimulus(1'b0, 2'd0, P1, 1'b1, 1'b0);
        tick();
        checkOutput("arst_after_drain", outValid, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
